// File: rtl/one_wire_rom_reader.sv
// 1-Wire bus master front end: reset/presence, Read ROM (0x33), 64 timed read
// slots, then a gap-free 64-cycle replay of the ROM ID for the CRC-8 stage.
module one_wire_rom_reader #(
    parameter int CLKS_PER_US = 50,
    parameter int T_RSTL_US   = 480,
    parameter int T_PDS_US    = 70,
    parameter int T_RSTH_US   = 480,
    parameter int T_SLOT_US   = 65,
    parameter int T_LOW1_US   = 6,
    parameter int T_LOW0_US   = 60,
    parameter int T_RDS_US    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ow_in,
    output logic        ow_drive_low,
    output logic        busy,
    output logic        done,
    output logic        presence_err,
    output logic [63:0] rom_id,
    output logic        crc_start,
    output logic        crc_bit,
    output logic [2:0]  dbg_state
);

    localparam int N_RSTL = T_RSTL_US * CLKS_PER_US;
    localparam int N_RSTH = T_RSTH_US * CLKS_PER_US;
    localparam int N_SLOT = T_SLOT_US * CLKS_PER_US;
    localparam int N_MAX0 = (N_RSTL > N_RSTH) ? N_RSTL : N_RSTH;
    localparam int N_MAX  = (N_MAX0 > N_SLOT) ? N_MAX0 : N_SLOT;
    localparam int TW     = $clog2(N_MAX + 1);

    localparam logic [TW-1:0] L_RSTL     = TW'(N_RSTL);
    localparam logic [TW-1:0] L_RSTH     = TW'(N_RSTH);
    localparam logic [TW-1:0] L_SLOT     = TW'(N_SLOT);
    localparam logic [TW-1:0] L_ONE      = TW'(1);
    // The timer counts down from the phase length, so "cycle N of the phase"
    // corresponds to timer == length - N + 1 and "elapsed E" to length - E.
    localparam logic [TW-1:0] L_PDS_AT   = TW'(N_RSTH - T_PDS_US * CLKS_PER_US + 1);
    localparam logic [TW-1:0] L_RDS_AT   = TW'(N_SLOT - T_RDS_US * CLKS_PER_US);
    localparam logic [TW-1:0] L_LOW1_END = TW'(N_SLOT - T_LOW1_US * CLKS_PER_US);
    localparam logic [TW-1:0] L_LOW0_END = TW'(N_SLOT - T_LOW0_US * CLKS_PER_US);
    localparam logic [7:0]    READ_ROM   = 8'h33;

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_HIGH, WR_SLOT, RD_SLOT, STREAM, FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [5:0]     idx_q, idx_d;
    logic           presence_q, presence_d;
    logic           perr_q, perr_d;
    logic [63:0]    rom_q, rom_d;
    logic           drive_q, drive_d;
    logic [1:0]     sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            presence_q <= 1'b0;
            perr_q     <= 1'b0;
            rom_q      <= '0;
            drive_q    <= 1'b0;
            sync_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            presence_q <= presence_d;
            perr_q     <= perr_d;
            rom_q      <= rom_d;
            drive_q    <= drive_d;
            sync_q     <= {sync_q[0], ow_in};
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        idx_d      = idx_q;
        presence_d = presence_q;
        perr_d     = perr_q;
        rom_d      = rom_q;
        drive_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RST_LOW;
                    timer_d    = L_RSTL;
                    perr_d     = 1'b0;
                    presence_d = 1'b0;
                end
            end
            RST_LOW: begin
                timer_d = timer_q - L_ONE;
                if (timer_q == L_ONE) begin
                    state_d = RST_HIGH;
                    timer_d = L_RSTH;
                end
            end
            RST_HIGH: begin
                timer_d = timer_q - L_ONE;
                if (timer_q == L_PDS_AT) presence_d = ~sync_q[1];
                if (timer_q == L_ONE) begin
                    if (presence_q) begin
                        state_d = WR_SLOT;
                        timer_d = L_SLOT;
                        idx_d   = '0;
                    end else begin
                        state_d = FINISH;
                        perr_d  = 1'b1;
                    end
                end
            end
            WR_SLOT: begin
                timer_d = timer_q - L_ONE;
                if (timer_q == L_ONE) begin
                    timer_d = L_SLOT;
                    if (idx_q == 6'd7) begin
                        state_d = RD_SLOT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            RD_SLOT: begin
                timer_d = timer_q - L_ONE;
                if (timer_q == L_RDS_AT) rom_d[idx_q] = sync_q[1];
                if (timer_q == L_ONE) begin
                    timer_d = L_SLOT;
                    if (idx_q == 6'd63) begin
                        state_d = STREAM;
                        timer_d = '0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            STREAM: begin
                if (idx_q == 6'd63) begin
                    state_d = FINISH;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus drive is derived from the next state so the register lines up
        // with the phase it belongs to.
        case (state_d)
            RST_LOW: drive_d = 1'b1;
            WR_SLOT: drive_d = timer_d > (READ_ROM[idx_d[2:0]] ? L_LOW1_END : L_LOW0_END);
            RD_SLOT: drive_d = timer_d > L_LOW1_END;
            default: drive_d = 1'b0;
        endcase
    end

    assign ow_drive_low = drive_q;
    assign busy         = (state_q != IDLE) && (state_q != FINISH);
    assign done         = (state_q == FINISH);
    assign presence_err = perr_q;
    assign rom_id       = rom_q;
    assign crc_start    = (state_q == STREAM) && (idx_q == 6'd0);
    assign crc_bit      = (state_q == STREAM) ? rom_q[idx_q] : 1'b0;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_one_wire_rom_reader.sv
// Bench for one_wire_rom_reader: a behavioural 1-Wire slave plus a scoreboard of
// expected low widths, slot starts and streamed ROM bits.
module tb_one_wire_rom_reader;

    localparam int CPU      = 4;
    localparam int T_SEQ    = 3840 + 72 * 260 + 64 + 1;
    localparam int T_NODEV  = 3841;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ow_in;
    logic        ow_drive_low, busy, done, presence_err, crc_start, crc_bit;
    logic [63:0] rom_id;
    logic [2:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    one_wire_rom_reader #(.CLKS_PER_US(CPU)) dut (
        .clk(clk), .rst(rst), .start(start), .ow_in(ow_in),
        .ow_drive_low(ow_drive_low), .busy(busy), .done(done),
        .presence_err(presence_err), .rom_id(rom_id),
        .crc_start(crc_start), .crc_bit(crc_bit), .dbg_state(dbg_state)
    );

    // ---------------- 1-Wire slave model ----------------
    logic [63:0] rom_v = 64'h7A00_0001_2345_6728;
    logic dev_en = 1'b0;
    logic prev_drv = 1'b0;
    int   dev_cyc = 0, dev_from = 0, dev_to = 0, low_run = 0, slot_cnt = 0;
    logic dev_low;

    assign dev_low = dev_en && (dev_cyc >= dev_from) && (dev_cyc < dev_to);
    assign ow_in   = ~(ow_drive_low | dev_low);

    always @(posedge clk) begin
        dev_cyc  <= dev_cyc + 1;
        prev_drv <= ow_drive_low;
        low_run  <= ow_drive_low ? low_run + 1 : 0;
        if (prev_drv && !ow_drive_low && low_run >= 1000) begin
            dev_from <= dev_cyc + 60;
            dev_to   <= dev_cyc + 400;
            slot_cnt <= 0;
        end else if (!prev_drv && ow_drive_low) begin
            slot_cnt <= slot_cnt + 1;
            if (slot_cnt >= 8 && slot_cnt < 72 && rom_v[6'(slot_cnt - 8)] == 1'b0) begin
                dev_from <= dev_cyc;
                dev_to   <= dev_cyc + 120;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [0:0]  exp_bits_q[$];
    int          obs_low_q[$];
    int          obs_rise_q[$];
    logic [0:0]  obs_bits_q[$];
    int          n_cs, done_k, busy_low;
    logic        pe_s;
    logic [63:0] rid_s;

    // Pulses start in the next cycle, then observes at every negedge; cycle 1
    // is the first cycle after the edge that accepts start.
    task automatic run_seq(input int pulse_k, input int lim);
        int k, cur_run, cap;
        logic prev;
        obs_low_q.delete(); obs_rise_q.delete(); obs_bits_q.delete();
        n_cs = 0; done_k = -1; busy_low = 0; cur_run = 0; cap = 0; prev = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (k <= lim) begin
            if (ow_drive_low) begin
                if (!prev) obs_rise_q.push_back(k);
                cur_run++;
            end else if (cur_run > 0) begin
                obs_low_q.push_back(cur_run);
                cur_run = 0;
            end
            prev = ow_drive_low;
            if (crc_start) begin n_cs++; cap = 64; end
            if (cap > 0) begin obs_bits_q.push_back(crc_bit); cap--; end
            if (done) begin
                done_k = k; pe_s = presence_err; rid_s = rom_id;
                if (busy) busy_low++;
                break;
            end
            if (!busy) busy_low++;
            @(negedge clk);
            k++;
            start = (k == pulse_k);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 7;
        if (ow_drive_low !== 1'b0) begin tests_failed++; $display("FAIL reset_drive got %b want 0", ow_drive_low); end
        if (busy !== 1'b0)         begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)         begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        if (presence_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr got %b want 0", presence_err); end
        if (crc_start !== 1'b0)    begin tests_failed++; $display("FAIL reset_crc_start got %b want 0", crc_start); end
        if (crc_bit !== 1'b0)      begin tests_failed++; $display("FAIL reset_crc_bit got %b want 0", crc_bit); end
        if (rom_id !== 64'd0)      begin tests_failed++; $display("FAIL reset_rom_id got %h want 0", rom_id); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_device();
        dev_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'd1920);
        run_seq(0, 5000);
        tests_run += 5;
        if (done_k != T_NODEV) begin tests_failed++; $display("FAIL nodev_done_cycle got %0d want %0d", done_k, T_NODEV); end
        if (pe_s !== 1'b1)     begin tests_failed++; $display("FAIL nodev_perr got %b want 1", pe_s); end
        if (n_cs != 0)         begin tests_failed++; $display("FAIL nodev_crc_start got %0d want 0", n_cs); end
        if (busy_low != 0)     begin tests_failed++; $display("FAIL nodev_busy got %0d bad cycles want 0", busy_low); end
        if (obs_low_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL nodev_low_count got %0d want %0d", obs_low_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_low_q.size() > 0) begin
            int o; logic [15:0] e;
            o = obs_low_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if (o != int'(e)) begin tests_failed++; $display("FAIL nodev_low_width got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_reset_mid();
        int k_rst;
        int dn;
        dev_en = 1'b1;
        k_rst = 3840 + 8 * 260 + 20 * 260 + 1 + 10;  // 10 cycles into read slot 20
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (k_rst - 1) @(negedge clk);
        tests_run += 2;
        if (ow_drive_low !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_drive got %b want 1", ow_drive_low); end
        if (busy !== 1'b1)         begin tests_failed++; $display("FAIL mid_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        tests_run += 2;
        if (ow_drive_low !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_drive got %b want 0", ow_drive_low); end
        if (busy !== 1'b0)         begin tests_failed++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        rst = 1'b0;
        repeat (2) begin @(negedge clk); if (done) dn++; end
        tests_run++;
        if (dn != 0) begin tests_failed++; $display("FAIL mid_no_done got %0d pulses want 0", dn); end
        // Rerun with a spurious start inside read slot 10; it must be ignored.
        run_seq(3840 + 8 * 260 + 10 * 260 + 50, 30000);
        tests_run += 5;
        if (done_k != T_SEQ)   begin tests_failed++; $display("FAIL rerun_done_cycle got %0d want %0d", done_k, T_SEQ); end
        if (rid_s !== rom_v)   begin tests_failed++; $display("FAIL rerun_rom_id got %h want %h", rid_s, rom_v); end
        if (pe_s !== 1'b0)     begin tests_failed++; $display("FAIL rerun_perr got %b want 0", pe_s); end
        if (n_cs != 1)         begin tests_failed++; $display("FAIL rerun_crc_start got %0d want 1", n_cs); end
        if (obs_rise_q.size() != 73) begin tests_failed++; $display("FAIL rerun_slots got %0d want 73", obs_rise_q.size()); end
    endtask

    task automatic test_rom_read();
        logic [15:0] cmd_w[8];
        cmd_w = '{16'd24, 16'd24, 16'd240, 16'd240, 16'd24, 16'd24, 16'd240, 16'd240};
        dev_en = 1'b1;
        exp_q.delete(); exp_bits_q.delete();
        exp_q.push_back(16'd1920);
        for (int i = 0; i < 8; i++) exp_q.push_back(cmd_w[i]);
        for (int i = 0; i < 64; i++) exp_q.push_back(16'd24);
        for (int i = 0; i < 64; i++) exp_bits_q.push_back(rom_v[i]);
        run_seq(0, 30000);
        tests_run += 6;
        if (done_k != T_SEQ)   begin tests_failed++; $display("FAIL rom_done_cycle got %0d want %0d", done_k, T_SEQ); end
        if (rid_s !== rom_v)   begin tests_failed++; $display("FAIL rom_id got %h want %h", rid_s, rom_v); end
        if (pe_s !== 1'b0)     begin tests_failed++; $display("FAIL rom_perr got %b want 0", pe_s); end
        if (n_cs != 1)         begin tests_failed++; $display("FAIL rom_crc_start got %0d want 1", n_cs); end
        if (busy_low != 0)     begin tests_failed++; $display("FAIL rom_busy got %0d bad cycles want 0", busy_low); end
        if (obs_low_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rom_low_count got %0d want %0d", obs_low_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_low_q.size() > 0) begin
            int o; logic [15:0] e;
            o = obs_low_q.pop_front(); e = exp_q.pop_front();
            tests_run++;
            if (o != int'(e)) begin tests_failed++; $display("FAIL rom_low_width got %0d want %0d", o, e); end
        end
        tests_run += 2;
        if (obs_rise_q.size() != 73) begin
            tests_failed++; $display("FAIL rom_rise_count got %0d want 73", obs_rise_q.size());
        end else if (obs_rise_q[1] != 3841) begin
            tests_failed++; $display("FAIL rom_first_slot got %0d want 3841", obs_rise_q[1]);
        end
        for (int i = 1; i + 1 < obs_rise_q.size(); i++) begin
            tests_run++;
            if (obs_rise_q[i+1] - obs_rise_q[i] != 260) begin
                tests_failed++; $display("FAIL rom_slot_span slot %0d got %0d want 260", i - 1, obs_rise_q[i+1] - obs_rise_q[i]);
            end
        end
        if (obs_bits_q.size() != 64) begin
            tests_failed++; $display("FAIL rom_stream_len got %0d want 64", obs_bits_q.size());
        end
        for (int i = 0; exp_bits_q.size() > 0 && obs_bits_q.size() > 0; i++) begin
            logic [0:0] o, e;
            o = obs_bits_q.pop_front(); e = exp_bits_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL rom_stream_bit %0d got %b want %b", i, o, e); end
        end
    endtask

    task automatic test_back_to_back();
        dev_en = 1'b0;
        run_seq(0, 5000);
        tests_run += 4;
        if (done_k != T_NODEV) begin tests_failed++; $display("FAIL b2b_done_cycle got %0d want %0d", done_k, T_NODEV); end
        if (pe_s !== 1'b1)     begin tests_failed++; $display("FAIL b2b_perr got %b want 1", pe_s); end
        if (rid_s !== rom_v)   begin tests_failed++; $display("FAIL b2b_rom_hold got %h want %h", rid_s, rom_v); end
        if (obs_rise_q.size() == 0 || obs_rise_q[0] != 1) begin
            tests_failed++; $display("FAIL b2b_start_accept got %0d rises want first at 1", obs_rise_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_device();
        test_reset_mid();
        test_rom_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/one_wire_rom_reader.md
Name: one_wire_rom_reader

Overview:
- Bus-side front end that sits directly upstream of the 1-Wire CRC-8 checker.
- Issues a 1-Wire reset, detects the presence pulse and sends the Read ROM command (0x33).
- Reads the 64-bit ROM ID using timed read slots.
- Replays the ID as a contiguous 64-cycle bit stream: a start pulse plus one bit per clock, which is what the CRC stage consumes.

Parameters:
- CLKS_PER_US, 50, clock cycles per microsecond; all slot timing derives from this.
- T_RSTL_US, 480, reset-low duration.
- T_PDS_US, 70, presence sample point, measured after reset release.
- T_RSTH_US, 480, total high time after reset release (includes the sample point).
- T_SLOT_US, 65, total length of a write or read slot, recovery included.
- T_LOW1_US, 6, low time for write-1 and for the read-slot initiation.
- T_LOW0_US, 60, low time for write-0.
- T_RDS_US, 15, read sample point, measured from slot start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request to run a full ROM read
- ow_in  in  1  raw bus level; double-flop synchronised internally
- ow_drive_low  out  1  1 = pull bus low (open-drain enable); 0 = release
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of a sequence
- presence_err  out  1  valid with done; 1 = no presence pulse seen
- rom_id  out  64  captured ROM; bit 0 is the first bit received
- crc_start  out  1  one-cycle pulse coincident with stream bit 0
- crc_bit  out  1  serial ROM bit for the CRC stage

Behaviour:
- Reset (asynchronous, immediate):
  - ow_drive_low=0, busy=0, done=0, presence_err=0, crc_start=0, crc_bit=0, rom_id=0.
  - FSM goes to IDLE; the timer and bit counter are cleared.
  - Reset mid-sequence releases the bus at once; no partial done is produced.
- Timer: a single down-counter, wide enough for T_RSTH_US*CLKS_PER_US. It is loaded at each phase entry. A phase ends when the count reaches 1, so the phase lasts exactly N cycles.
- States:
  - IDLE: start=1 → RST_LOW, busy=1, presence_err cleared. start while busy is ignored.
  - RST_LOW: drive low for T_RSTL_US*CLKS_PER_US cycles → RST_HIGH.
  - RST_HIGH:
    - Release the bus.
    - At cycle T_PDS_US*CLKS_PER_US, sample the synchronised ow_in; 0 = presence.
    - After T_RSTH_US*CLKS_PER_US cycles: if presence → WR_SLOT with bit index 0; else → FINISH with presence_err=1.
  - WR_SLOT:
    - Command 0x33 is sent LSB first: 1,1,0,0,1,1,0,0.
    - Drive low for T_LOW1 (bit=1) or T_LOW0 (bit=0), then release until T_SLOT_US elapses.
    - After 8 slots → RD_SLOT with index 0.
  - RD_SLOT:
    - Drive low for T_LOW1_US, then release.
    - At T_RDS_US from slot start, sample the synchronised ow_in and write it into rom_id[index].
    - The slot ends at T_SLOT_US. After 64 slots → STREAM.
  - STREAM:
    - 64 consecutive cycles, i = 0..63, with crc_bit = rom_id[i].
    - crc_start=1 only in cycle i=0.
    - No gaps: the downstream stage samples one bit per clock after start.
    - Then → FINISH.
  - FINISH: done=1 for one cycle, busy=0, crc_bit=0 → IDLE. presence_err holds until the next accepted start.
- ow_drive_low is registered (no glitches) and is 0 in IDLE, STREAM and FINISH.
- Synchroniser latency (2 cycles) is absorbed by the sample points; it is not compensated.
- rom_id bits beyond the current read index hold their previous value until written. rom_id is stable from STREAM onward.
- Sequence length in cycles: reset phase 960*CLKS_PER_US, plus 72 slots × 65*CLKS_PER_US, plus 64 stream cycles, plus 1 for FINISH.

Test Plan:
- No device (ow_in held 1), CLKS_PER_US=4, start pulse:
  - ow_drive_low is low for exactly 1920 cycles.
  - done arrives at cycle 3841 with presence_err=1; crc_start never asserts.
- Device model with presence, CLKS_PER_US=4:
  - Command slot low widths measure 24,24,240,240,24,24,240,240 cycles.
  - Each slot spans 260 cycles.
- Model returns ROM 64'h7A00_0001_2345_6728 (LSB first):
  - rom_id equals that value at done; presence_err=0.
  - crc_bit over the 64 cycles after crc_start reproduces bits 0..63 in order.
  - crc_start is high in exactly one cycle.
- start re-pulsed during RD_SLOT: ignored; timing and the captured rom_id are unchanged.
- rst asserted mid-way through read slot 20:
  - ow_drive_low=0 and busy=0 in the same cycle; no done.
  - A following start completes a full, correct read.
- Back-to-back runs, with start the cycle after done: second sequence begins correctly and presence_err is recomputed.
